// File: rtl/operand_loader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | operand_loader: two-step 4-bit operand entry with debounced load/clear keys |
// | Optional: OPERAND_LOADER_COUNT_EN adds a wrapping committed-pair counter.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module operand_loader #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [3:0] switch,
    input  logic       key_load_n,
    input  logic       key_clear_n,
    output logic [7:0] operands,
    output logic       valid,
    output logic       new_pair,
    output logic [1:0] phase
`ifdef OPERAND_LOADER_COUNT_EN
    ,
    output logic [7:0] load_count
`endif
);

    localparam int c_cnt_w = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_cnt_w-1:0] c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [0:0] {
        GET_A = 1'b0,
        GET_B = 1'b1
    } state_t;

    // Key vectors: bit 0 = load, bit 1 = clear
    logic [1:0] r_key_meta;
    logic [1:0] r_key_sync;
    logic [3:0] r_sw_meta;
    logic [3:0] r_sw_sync;
    logic [1:0] w_press;
    logic       w_ev_load;
    logic       w_ev_clear;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_stage_a;
    logic [3:0] w_stage_a_nxt;
    logic [7:0] r_operands;
    logic [7:0] w_operands_nxt;
    logic       r_valid;
    logic       w_valid_nxt;
    logic       r_new_pair;
    logic       w_new_pair_nxt;
    logic [1:0] r_phase;
    logic [1:0] w_phase_nxt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_key_meta <= 2'b11;
            r_key_sync <= 2'b11;
            r_sw_meta  <= 4'h0;
            r_sw_sync  <= 4'h0;
        end else begin
            r_key_meta <= {key_clear_n, key_load_n};
            r_key_sync <= r_key_meta;
            r_sw_meta  <= switch;
            r_sw_sync  <= r_sw_meta;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_debounce
            logic [c_cnt_w-1:0] r_cnt;
            logic               r_db;
            logic               r_db_d;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    r_cnt  <= '0;
                    r_db   <= 1'b1;
                    r_db_d <= 1'b1;
                end else begin
                    r_db_d <= r_db;
                    if (r_key_sync[gi] == r_db) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_cnt_max) begin
                        r_db  <= r_key_sync[gi];
                        r_cnt <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
            end

            // Falling debounced level seen one cycle late gives a single pulse
            assign w_press[gi] = r_db_d & ~r_db;
        end
    endgenerate

    assign w_ev_load  = w_press[0];
    assign w_ev_clear = w_press[1];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= GET_A;
            r_stage_a  <= 4'h0;
            r_operands <= 8'h00;
            r_valid    <= 1'b0;
            r_new_pair <= 1'b0;
            r_phase    <= 2'b01;
        end else begin
            r_state    <= w_state_nxt;
            r_stage_a  <= w_stage_a_nxt;
            r_operands <= w_operands_nxt;
            r_valid    <= w_valid_nxt;
            r_new_pair <= w_new_pair_nxt;
            r_phase    <= w_phase_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_stage_a_nxt  = r_stage_a;
        w_operands_nxt = r_operands;
        w_valid_nxt    = r_valid;
        w_new_pair_nxt = 1'b0;
        // Clear has priority so a coincident load is dropped
        if (w_ev_clear) begin
            w_state_nxt    = GET_A;
            w_stage_a_nxt  = 4'h0;
            w_operands_nxt = 8'h00;
            w_valid_nxt    = 1'b0;
        end else if (w_ev_load) begin
            case (r_state)
                GET_A: begin
                    w_stage_a_nxt = r_sw_sync;
                    w_state_nxt   = GET_B;
                end
                GET_B: begin
                    w_operands_nxt = {r_stage_a, r_sw_sync};
                    w_valid_nxt    = 1'b1;
                    w_new_pair_nxt = 1'b1;
                    w_state_nxt    = GET_A;
                end
                default: begin
                    w_state_nxt = GET_A;
                end
            endcase
        end
        w_phase_nxt = (w_state_nxt == GET_B) ? 2'b10 : 2'b01;
    end

    assign operands = r_operands;
    assign valid    = r_valid;
    assign new_pair = r_new_pair;
    assign phase    = r_phase;

`ifdef OPERAND_LOADER_COUNT_EN
    logic [7:0] r_load_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_load_count <= 8'h00;
        end else if (w_new_pair_nxt) begin
            r_load_count <= r_load_count + 8'h01;
        end
    end

    assign load_count = r_load_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_operand_loader.sv
`default_nettype none
// Bench for operand_loader: spec-level model checked every cycle plus literal pins.
`timescale 1ns/1ps
module tb_operand_loader;

    localparam int DB = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [3:0] switch = 4'h0;
    logic       key_load_n = 1'b1;
    logic       key_clear_n = 1'b1;
    logic [7:0] operands;
    logic       valid;
    logic       new_pair;
    logic [1:0] phase;
`ifdef OPERAND_LOADER_COUNT_EN
    logic [7:0] load_count;
`endif

    operand_loader #(.DEBOUNCE_CYCLES(DB)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .switch      (switch),
        .key_load_n  (key_load_n),
        .key_clear_n (key_clear_n),
        .operands    (operands),
        .valid       (valid),
        .new_pair    (new_pair),
        .phase       (phase)
`ifdef OPERAND_LOADER_COUNT_EN
        ,
        .load_count  (load_count)
`endif
    );

    always #5 clk = ~clk;

    int n_tot = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: inputs are seen two cycles late, a key is accepted
    // after DB consecutive cycles of disagreement, and its press acts one
    // cycle after the accepted fall.
    logic       qL[$];
    logic       qC[$];
    logic [3:0] qS[$];
    logic       hL[$];
    logic       hC[$];
    logic       m_dbL, m_dbC, m_dbL_prev, m_dbC_prev;
    logic       m_inB;
    logic [3:0] m_a;
    logic [7:0] m_ops;
    logic       m_valid, m_np;
    logic [7:0] m_cnt;

    task automatic model_reset();
        qL = '{1'b1, 1'b1};
        qC = '{1'b1, 1'b1};
        qS = '{4'h0, 4'h0};
        hL = {};
        hC = {};
        m_dbL = 1'b1; m_dbC = 1'b1; m_dbL_prev = 1'b1; m_dbC_prev = 1'b1;
        m_inB = 1'b0; m_a = 4'h0; m_ops = 8'h00; m_valid = 1'b0; m_np = 1'b0;
        m_cnt = 8'h00;
    endtask

    function automatic logic settled(input logic h[$], input logic db);
        logic all_diff;
        all_diff = (h.size() == DB);
        foreach (h[i]) if (h[i] == db) all_diff = 1'b0;
        return all_diff;
    endfunction

    task automatic model_step();
        logic       sL, sC, evL, evC;
        logic [3:0] sS;
        sL = qL.pop_front(); qL.push_back(key_load_n);
        sC = qC.pop_front(); qC.push_back(key_clear_n);
        sS = qS.pop_front(); qS.push_back(switch);
        evL = m_dbL_prev & ~m_dbL;
        evC = m_dbC_prev & ~m_dbC;
        m_dbL_prev = m_dbL;
        m_dbC_prev = m_dbC;
        hL.push_back(sL); if (hL.size() > DB) void'(hL.pop_front());
        hC.push_back(sC); if (hC.size() > DB) void'(hC.pop_front());
        if (settled(hL, m_dbL)) m_dbL = ~m_dbL;
        if (settled(hC, m_dbC)) m_dbC = ~m_dbC;
        m_np = 1'b0;
        if (evC) begin
            m_inB = 1'b0; m_a = 4'h0; m_ops = 8'h00; m_valid = 1'b0;
        end else if (evL) begin
            if (!m_inB) begin
                m_a = sS; m_inB = 1'b1;
            end else begin
                m_ops = {m_a, sS}; m_valid = 1'b1; m_np = 1'b1; m_inB = 1'b0;
                m_cnt = m_cnt + 8'h01;
            end
        end
    endtask

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) model_reset();
        else          model_step();
    end

    logic       chk_en = 1'b0;
    int         np_count = 0;
    int         ph_changes = 0;
    logic [1:0] last_phase = 2'b01;

    always @(negedge clk) begin
        if (chk_en) begin
            check("operands", operands, m_ops);
            check("valid", valid, m_valid);
            check("new_pair", new_pair, m_np);
            check("phase", phase, m_inB ? 2'b10 : 2'b01);
`ifdef OPERAND_LOADER_COUNT_EN
            check("load_count", load_count, m_cnt);
`endif
            if (new_pair === 1'b1) np_count++;
            if (phase !== last_phase) ph_changes++;
            last_phase = phase;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press_load(input int hold, input int gap);
        key_load_n = 1'b0; tick(hold);
        key_load_n = 1'b1; tick(gap);
    endtask

    task automatic enter(input logic [3:0] v);
        switch = v; tick(4);
        press_load(20, 20);
    endtask

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation did not complete at %0t", $time);
        $fatal(1, "timeout");
    end

    initial begin : stim
        int np0, ph0;
        tick(3);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        tick(1);
        check("rst_operands", operands, 8'h00);
        check("rst_valid", valid, 1'b0);
        check("rst_new_pair", new_pair, 1'b0);
        check("rst_phase", phase, 2'b01);

        // First pair 9,3
        np0 = np_count;
        enter(4'h9);
        check("after_A_phase", phase, 2'b10);
        enter(4'h3);
        check("pair93_operands", operands, 8'h93);
        check("pair93_valid", valid, 1'b1);
        check("pair93_phase", phase, 2'b01);
        check("pair93_np_once", np_count - np0, 1);
        check("model_pin_93", m_ops, 8'h93);

        // Bouncing load while entering A=5; previous pair must persist
        switch = 4'h5; tick(4);
        ph0 = ph_changes;
        key_load_n = 1'b1; tick(1);
        key_load_n = 1'b0; tick(1);
        key_load_n = 1'b1; tick(1);
        key_load_n = 1'b0; tick(1);
        tick(10);
        key_load_n = 1'b1; tick(20);
        check("bounce_one_event", ph_changes - ph0, 1);
        check("holdA_phase", phase, 2'b10);
        check("holdA_operands", operands, 8'h93);
        check("holdA_valid", valid, 1'b1);

        // Switch activity alone changes nothing
        for (int i = 0; i < 10; i++) begin
            switch = 4'(i * 7); tick(1);
        end
        tick(4);
        check("switch_only_operands", operands, 8'h93);

        // Clear
        key_clear_n = 1'b0; tick(20);
        key_clear_n = 1'b1; tick(20);
        check("clear_operands", operands, 8'h00);
        check("clear_valid", valid, 1'b0);
        check("clear_phase", phase, 2'b01);

        // Pair 2,C then A=7, then load+clear together in GET_B
        enter(4'h2);
        enter(4'hC);
        check("pair2C_operands", operands, 8'h2C);
        enter(4'h7);
        check("getB_phase", phase, 2'b10);
        np0 = np_count;
        key_load_n = 1'b0; key_clear_n = 1'b0; tick(20);
        key_load_n = 1'b1; key_clear_n = 1'b1; tick(20);
        check("both_phase", phase, 2'b01);
        check("both_valid", valid, 1'b0);
        check("both_operands", operands, 8'h00);
        check("both_no_np", np_count - np0, 0);

        // Reset mid-debounce while in GET_B with load held
        enter(4'h4);
        key_load_n = 1'b0; tick(4);
        @(posedge clk); #2;
        reset_n = 1'b0;
        #1;
        check("midrst_operands", operands, 8'h00);
        check("midrst_valid", valid, 1'b0);
        check("midrst_new_pair", new_pair, 1'b0);
        check("midrst_phase", phase, 2'b01);
        @(posedge clk); #2;
        reset_n = 1'b1;
        tick(1);
        ph0 = ph_changes;
        np0 = np_count;
        tick(20);
        check("held_key_one_event", ph_changes - ph0, 1);
        check("held_key_phase", phase, 2'b10);
        check("held_key_no_np", np_count - np0, 0);
        key_load_n = 1'b1; tick(20);
        key_clear_n = 1'b0; tick(20);
        key_clear_n = 1'b1; tick(20);
        check("final_clear_phase", phase, 2'b01);

`ifdef OPERAND_LOADER_COUNT_EN
        for (int p = 0; p < 257; p++) begin
            switch = 4'(p); tick(3);
            press_load(10, 10);
            press_load(10, 10);
        end
        check("load_count_wrap", load_count, 8'h01);
`endif

        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/operand_loader.md
Name: operand_loader

Overview:
- Upstream stage for the 4-bit magnitude comparator display block.
- Lets the user enter two 4-bit operands one after the other from switch[3:0], using a debounced KEY button for load and a second one for clear.
- Presents a stable operand pair on operands[7:0] (A in [7:4], B in [3:0]), the same bit layout the comparator takes on switch[7:0].
- The comparator only ever sees complete, atomically updated pairs.

Parameters:
- DEBOUNCE_CYCLES, 500000, number of consecutive stable clocks required before a key level change is accepted (10 ms at 50 MHz). Minimum legal value 2.

Ports:
- clk  input  1  system clock (50 MHz board clock)
- reset_n  input  1  asynchronous active-low reset
- switch  input  4  raw operand value from slide switches
- key_load_n  input  1  raw load button, active-low
- key_clear_n  input  1  raw clear button, active-low
- operands  output  8  committed pair {A,B}
- valid  output  1  high while operands holds a completed pair
- new_pair  output  1  one-cycle pulse on the cycle operands updates
- phase  output  2  entry-phase LED indication: 01 = awaiting A, 10 = awaiting B

Behaviour:
- Reset (asynchronous, active-low): all outputs and internal registers take their reset values.
  - operands=8'h00, valid=0, new_pair=0, phase=2'b01, state=GET_A.
  - Staged A = 0. Debounced key levels = 1 (released). Synchronizers = 1 for keys, 0 for switch.
- Synchronizers: key_load_n, key_clear_n and switch[3:0] each pass through a 2-FF synchronizer before use.
- Debounce, one instance per key:
  - Counter increments while the synchronized level differs from the debounced level; it resets to 0 whenever they match.
  - When the count reaches DEBOUNCE_CYCLES-1 and the levels still differ, the debounced level flips and the counter resets.
  - Press event: one-clock pulse in the cycle after the debounced level falls 1->0.
  - Release produces no event. Holding a key produces exactly one event.
- FSM, two states:
  - GET_A: load event -> staged A <= synced switch; go to GET_B.
  - GET_B: load event -> operands <= {staged A, synced switch}; valid <= 1; new_pair pulses 1 clock; go to GET_A.
  - Both updates are registered on the clock edge at the end of the event cycle.
- Holding the previous pair: after the first pair, operands and valid keep their values while the next A is being entered. The comparator keeps showing the last committed result.
- Clear event, in any state:
  - state <= GET_A, staged A <= 0, operands <= 0, valid <= 0, new_pair = 0.
- Simultaneous load and clear events in the same cycle: clear wins and the load is discarded.
- phase is decoded from the state as registered outputs: GET_A -> 01, GET_B -> 10. It is never 00 or 11.
- Switch changes alone never alter any output.
- Latency: a raw key edge held stable produces its press event 2 (synchronizer) + DEBOUNCE_CYCLES + 1 clocks later, ±1. The capture is visible on outputs the following cycle.
- Reset asserted mid-debounce or mid-pair: everything returns to reset values immediately. A key already held at reset release produces an event once it has been debounced low.
- No arithmetic wrap: operand width is fixed at 4 bits per slot and no truncation occurs.

Optional Feature:
- Macro: OPERAND_LOADER_COUNT_EN.
- Defined: adds output port load_count [7:0].
  - Resets to 0 and increments on every new_pair pulse.
  - Wraps 255 -> 0. Clear does not reset it; only reset_n does.
- Undefined: port and counter are absent. All other behaviour is identical.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset release -> operands=00, valid=0, new_pair=0, phase=01 on the first clock.
- switch=4'h9, press load (held 20 clk), then switch=4'h3, press load -> after second event operands=8'h93, valid=1, new_pair high exactly 1 clk, phase=01.
- Load key bouncing 1,0,1,0 with 1-clk widths, then held low 10 clk -> exactly one press event, phase 01->10 once.
- With pair 8'h93 committed, enter A=4'h5 only -> operands stays 8'h93, valid=1, phase=10; then clear -> operands=00, valid=0, phase=01.
- Load and clear debounced low on the same cycle while in GET_B -> state GET_A, valid=0, no new_pair pulse.
- Assert reset_n low for 1 clk while in GET_B with a debounce count in progress -> outputs immediately at reset values; a held key yields a single event after release of reset. With OPERAND_LOADER_COUNT_EN defined: 257 pairs -> load_count=1.
